mc_control_unit: RTL and testbench

Parametrised multicycle control FSM for the MIPS-subset datapath. It succeeds the first-generation controller with these additions:
- configurable memory latency
- load/store, branch and jump sequences
- an unknown-funct trap
- a generic exception sequencer with a cause code
- an asynchronous active-low reset
- a state debug port
It drives every datapath strobe and mux select from the decoded opcode/funct, and the ALU overflow and zero flags.

---
 rtl/mc_ctrl_pkg.sv | 99 +++++++++
 rtl/mc_mem_wait.sv | 26 ++
 rtl/mc_control_unit.sv | 251 +++++++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared states, opcode/funct constants and select encodings for mc_control_unit
package mc_ctrl_pkg;

    typedef enum logic [5:0] {
        RESET_INIT  = 6'd0,
        STACK_WR    = 6'd1,
        FETCH       = 6'd2,
        FETCH_LD    = 6'd3,
        DECODE0     = 6'd4,
        DECODE1     = 6'd5,
        R_EXEC      = 6'd6,
        R_WB        = 6'd7,
        ADDI_EXEC   = 6'd8,
        ADDI_WB     = 6'd9,
        MEM_ADDR    = 6'd10,
        LW_READ     = 6'd11,
        LW_MDR      = 6'd12,
        LW_WB       = 6'd13,
        SW_WRITE    = 6'd14,
        BRANCH      = 6'd15,
        BRANCH_TAKE = 6'd16,
        JUMP        = 6'd17,
        EXC_READ    = 6'd18,
        EXC_EPC     = 6'd19,
        EXC_MDR     = 6'd20,
        EXC_PC      = 6'd21
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;

    localparam logic [1:0] IORD_PC     = 2'b00;
    localparam logic [1:0] IORD_ALUOUT = 2'b01;
    localparam logic [1:0] IORD_VEC    = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_SP = 2'b10;

    localparam logic [3:0] DSRC_ALUOUT  = 4'b0000;
    localparam logic [3:0] DSRC_MDR     = 4'b0001;
    localparam logic [3:0] DSRC_SP_INIT = 4'b1000;

    localparam logic [1:0] SRCA_PC = 2'b00;
    localparam logic [1:0] SRCA_A  = 2'b01;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [2:0] PCSRC_ALU    = 3'b000;
    localparam logic [2:0] PCSRC_ALUOUT = 3'b001;
    localparam logic [2:0] PCSRC_JUMP   = 3'b010;
    localparam logic [2:0] PCSRC_VEC    = 3'b011;

    localparam logic [1:0] CAUSE_OPCODE = 2'b00;
    localparam logic [1:0] CAUSE_OVF    = 2'b01;
    localparam logic [1:0] CAUSE_FUNCT  = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       mdr_write;
        logic       a_write;
        logic       b_write;
        logic       aluout_write;
        logic       epc_write;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] excp_sel;
        logic [1:0] iord_sel;
        logic [1:0] reg_dst_sel;
        logic [3:0] data_src_sel;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] pc_src;
        logic [2:0] alu_op;
    } ctrl_t;

    // States that hold mem_read for the full memory latency.
    function automatic logic is_mem_wait(state_t s);
        return (s == FETCH) || (s == LW_READ) || (s == EXC_READ);
    endfunction

endpackage

// File: rtl/mc_mem_wait.sv
// rtl/mc_mem_wait.sv - memory-latency down-counter, done flags the last wait cycle
module mc_mem_wait #(
    parameter int MEM_LAT = 3,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic done
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CNT_W'(MEM_LAT);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle MIPS-subset control FSM with registered strobes and selects
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_LAT    = 3,
    parameter int CNT_W      = 5,
    parameter int STACK_INIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       overflow,
    input  logic       zero,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       pc_write,
    output logic       mdr_write,
    output logic       a_write,
    output logic       b_write,
    output logic       aluout_write,
    output logic       epc_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] excp_sel,
    output logic [1:0] iord_sel,
    output logic [1:0] reg_dst_sel,
    output logic [3:0] data_src_sel,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] pc_src,
    output logic [2:0] alu_op,
    output logic [5:0] state_dbg
);

    state_t     state_q, state_d;
    logic [1:0] cause_q, cause_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic       wait_load, wait_done;
    logic       funct_known;

    assign funct_known = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND);
    assign wait_load   = is_mem_wait(state_d) && (state_d != state_q);

    mc_mem_wait #(.MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) u_mem_wait (
        .clk   (clk),
        .reset (reset),
        .load  (wait_load),
        .done  (wait_done)
    );

    // Flags are judged on the edge leaving the execute cycle so a trapped op never writes back.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            RESET_INIT:  state_d = (STACK_INIT != 0) ? STACK_WR : FETCH;
            STACK_WR:    state_d = FETCH;
            FETCH:       if (wait_done) state_d = FETCH_LD;
            FETCH_LD:    state_d = DECODE0;
            DECODE0:     state_d = DECODE1;
            DECODE1: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (funct_known) begin
                            state_d = R_EXEC;
                        end else begin
                            state_d = EXC_READ;
                            cause_d = CAUSE_FUNCT;
                        end
                    end
                    OP_ADDI:      state_d = ADDI_EXEC;
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d = EXC_READ;
                        cause_d = CAUSE_OPCODE;
                    end
                endcase
            end
            R_EXEC: begin
                if (overflow && (funct != FN_AND)) begin
                    state_d = EXC_READ;
                    cause_d = CAUSE_OVF;
                end else begin
                    state_d = R_WB;
                end
            end
            ADDI_EXEC: begin
                if (overflow) begin
                    state_d = EXC_READ;
                    cause_d = CAUSE_OVF;
                end else begin
                    state_d = ADDI_WB;
                end
            end
            R_WB, ADDI_WB: state_d = FETCH;
            MEM_ADDR:    state_d = (opcode == OP_LW) ? LW_READ : SW_WRITE;
            LW_READ:     if (wait_done) state_d = LW_MDR;
            LW_MDR:      state_d = LW_WB;
            LW_WB:       state_d = FETCH;
            SW_WRITE:    state_d = FETCH;
            BRANCH:      state_d = zero ? BRANCH_TAKE : FETCH;
            BRANCH_TAKE: state_d = FETCH;
            JUMP:        state_d = FETCH;
            EXC_READ:    if (wait_done) state_d = EXC_EPC;
            EXC_EPC:     state_d = EXC_MDR;
            EXC_MDR:     state_d = EXC_PC;
            EXC_PC:      state_d = FETCH;
            default:     state_d = RESET_INIT;
        endcase
    end

    // Control word for the cycle about to start; registered so every output is flop-driven.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            STACK_WR: begin
                ctrl_d.reg_write    = 1'b1;
                ctrl_d.reg_dst_sel  = DST_SP;
                ctrl_d.data_src_sel = DSRC_SP_INIT;
            end
            FETCH: begin
                ctrl_d.mem_read  = 1'b1;
                ctrl_d.iord_sel  = IORD_PC;
                ctrl_d.alu_src_a = SRCA_PC;
                ctrl_d.alu_src_b = SRCB_4;
                ctrl_d.alu_op    = ALU_ADD;
            end
            FETCH_LD: begin
                ctrl_d.ir_write  = 1'b1;
                ctrl_d.pc_write  = 1'b1;
                ctrl_d.pc_src    = PCSRC_ALU;
                ctrl_d.alu_src_b = SRCB_4;
                ctrl_d.alu_op    = ALU_ADD;
            end
            DECODE0: begin
                ctrl_d.alu_src_a    = SRCA_PC;
                ctrl_d.alu_src_b    = SRCB_IMM_SH;
                ctrl_d.alu_op       = ALU_ADD;
                ctrl_d.aluout_write = 1'b1;
            end
            DECODE1: begin
                ctrl_d.a_write = 1'b1;
                ctrl_d.b_write = 1'b1;
            end
            R_EXEC: begin
                ctrl_d.alu_src_a    = SRCA_A;
                ctrl_d.alu_src_b    = SRCB_B;
                ctrl_d.alu_op       = (funct == FN_SUB) ? ALU_SUB :
                                      (funct == FN_AND) ? ALU_AND : ALU_ADD;
                ctrl_d.aluout_write = 1'b1;
            end
            ADDI_EXEC, MEM_ADDR: begin
                ctrl_d.alu_src_a    = SRCA_A;
                ctrl_d.alu_src_b    = SRCB_IMM;
                ctrl_d.alu_op       = ALU_ADD;
                ctrl_d.aluout_write = 1'b1;
            end
            R_WB: begin
                ctrl_d.reg_write    = 1'b1;
                ctrl_d.reg_dst_sel  = DST_RD;
                ctrl_d.data_src_sel = DSRC_ALUOUT;
            end
            ADDI_WB: begin
                ctrl_d.reg_write    = 1'b1;
                ctrl_d.reg_dst_sel  = DST_RT;
                ctrl_d.data_src_sel = DSRC_ALUOUT;
            end
            LW_READ: begin
                ctrl_d.mem_read = 1'b1;
                ctrl_d.iord_sel = IORD_ALUOUT;
            end
            LW_MDR: begin
                ctrl_d.mdr_write = 1'b1;
                ctrl_d.iord_sel  = IORD_ALUOUT;
            end
            LW_WB: begin
                ctrl_d.reg_write    = 1'b1;
                ctrl_d.reg_dst_sel  = DST_RT;
                ctrl_d.data_src_sel = DSRC_MDR;
            end
            SW_WRITE: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.iord_sel  = IORD_ALUOUT;
            end
            BRANCH: begin
                ctrl_d.alu_src_a = SRCA_A;
                ctrl_d.alu_src_b = SRCB_B;
                ctrl_d.alu_op    = ALU_SUB;
            end
            BRANCH_TAKE: begin
                ctrl_d.pc_src   = PCSRC_ALUOUT;
                ctrl_d.pc_write = 1'b1;
            end
            JUMP: begin
                ctrl_d.pc_src   = PCSRC_JUMP;
                ctrl_d.pc_write = 1'b1;
            end
            EXC_READ, EXC_EPC, EXC_MDR: begin
                ctrl_d.excp_sel  = cause_d;
                ctrl_d.iord_sel  = IORD_VEC;
                ctrl_d.mem_read  = (state_d == EXC_READ);
                ctrl_d.epc_write = (state_d == EXC_EPC);
                ctrl_d.mdr_write = (state_d == EXC_MDR);
                ctrl_d.alu_src_a = SRCA_PC;
                ctrl_d.alu_src_b = SRCB_4;
                ctrl_d.alu_op    = ALU_SUB;
            end
            EXC_PC: begin
                ctrl_d.pc_src   = PCSRC_VEC;
                ctrl_d.pc_write = 1'b1;
            end
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RESET_INIT;
            cause_q <= CAUSE_OPCODE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign pc_write     = ctrl_q.pc_write;
    assign mdr_write    = ctrl_q.mdr_write;
    assign a_write      = ctrl_q.a_write;
    assign b_write      = ctrl_q.b_write;
    assign aluout_write = ctrl_q.aluout_write;
    assign epc_write    = ctrl_q.epc_write;
    assign mem_read     = ctrl_q.mem_read;
    assign mem_write    = ctrl_q.mem_write;
    assign ir_write     = ctrl_q.ir_write;
    assign reg_write    = ctrl_q.reg_write;
    assign excp_sel     = ctrl_q.excp_sel;
    assign iord_sel     = ctrl_q.iord_sel;
    assign reg_dst_sel  = ctrl_q.reg_dst_sel;
    assign data_src_sel = ctrl_q.data_src_sel;
    assign alu_src_a    = ctrl_q.alu_src_a;
    assign alu_src_b    = ctrl_q.alu_src_b;
    assign pc_src       = ctrl_q.pc_src;
    assign alu_op       = ctrl_q.alu_op;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - directed self-checking bench for mc_control_unit
module tb_mc_control_unit;

    typedef struct packed {
        logic       pc_write;
        logic       mdr_write;
        logic       a_write;
        logic       b_write;
        logic       aluout_write;
        logic       epc_write;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] excp_sel;
        logic [1:0] iord_sel;
        logic [1:0] reg_dst_sel;
        logic [3:0] data_src_sel;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] pc_src;
        logic [2:0] alu_op;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset, overflow, zero;
    logic [5:0] opcode, funct;
    obs_t       o3, o5;
    logic [5:0] sd3, sd5;

    int   checks = 0;
    int   errors = 0;
    obs_t tr[$];
    int   n_reg, n_epc, n_pcw, n_mrd, n_mwr, n_mdr, n_lwrd;

    always #5 clk = ~clk;

    mc_control_unit #(.MEM_LAT(3), .CNT_W(5), .STACK_INIT(1)) dut (
        .clk(clk), .reset(reset), .overflow(overflow), .zero(zero),
        .opcode(opcode), .funct(funct),
        .pc_write(o3.pc_write), .mdr_write(o3.mdr_write), .a_write(o3.a_write),
        .b_write(o3.b_write), .aluout_write(o3.aluout_write), .epc_write(o3.epc_write),
        .mem_read(o3.mem_read), .mem_write(o3.mem_write), .ir_write(o3.ir_write),
        .reg_write(o3.reg_write), .excp_sel(o3.excp_sel), .iord_sel(o3.iord_sel),
        .reg_dst_sel(o3.reg_dst_sel), .data_src_sel(o3.data_src_sel),
        .alu_src_a(o3.alu_src_a), .alu_src_b(o3.alu_src_b), .pc_src(o3.pc_src),
        .alu_op(o3.alu_op), .state_dbg(sd3)
    );

    mc_control_unit #(.MEM_LAT(5), .CNT_W(5), .STACK_INIT(0)) dut5 (
        .clk(clk), .reset(reset), .overflow(overflow), .zero(zero),
        .opcode(opcode), .funct(funct),
        .pc_write(o5.pc_write), .mdr_write(o5.mdr_write), .a_write(o5.a_write),
        .b_write(o5.b_write), .aluout_write(o5.aluout_write), .epc_write(o5.epc_write),
        .mem_read(o5.mem_read), .mem_write(o5.mem_write), .ir_write(o5.ir_write),
        .reg_write(o5.reg_write), .excp_sel(o5.excp_sel), .iord_sel(o5.iord_sel),
        .reg_dst_sel(o5.reg_dst_sel), .data_src_sel(o5.data_src_sel),
        .alu_src_a(o5.alu_src_a), .alu_src_b(o5.alu_src_b), .pc_src(o5.pc_src),
        .alu_op(o5.alu_op), .state_dbg(sd5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Trace from the cycle after an IR load up to (not including) the next IR load.
    task automatic run_instr(input bit sel5);
        obs_t o;
        bit   seen;
        seen = 1'b0;
        tr.delete();
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            o = sel5 ? o5 : o3;
            if (o.ir_write) seen = 1'b1;
            else tr.push_back(o);
        end
        chk("ir_reached", 32'(seen), 32'd1);
        n_reg = 0; n_epc = 0; n_pcw = 0; n_mrd = 0; n_mwr = 0; n_mdr = 0; n_lwrd = 0;
        foreach (tr[k]) begin
            n_reg += int'(tr[k].reg_write);
            n_epc += int'(tr[k].epc_write);
            n_pcw += int'(tr[k].pc_write);
            n_mrd += int'(tr[k].mem_read);
            n_mwr += int'(tr[k].mem_write);
            n_mdr += int'(tr[k].mdr_write);
            n_lwrd += int'(tr[k].mem_read && tr[k].iord_sel == 2'b01);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; overflow = 1'b0; zero = 1'b0;
        opcode = 6'b000000; funct = 6'b100000;
        tick(); tick();
        chk("rst_outs", 32'(o3), 32'd0);
        chk("rst_state", 32'(sd3), 32'd0);

        reset = 1'b1;
        tick();
        chk("init_reg_write", 32'(o3.reg_write), 32'd1);
        chk("init_dst", 32'(o3.reg_dst_sel), 32'd2);
        chk("init_dsrc", 32'(o3.data_src_sel), 32'd8);
        tick();
        chk("fetch_mem_read", 32'(o3.mem_read), 32'd1);
        reset = 1'b0;
        #1;
        chk("midfetch_rst_outs", 32'(o3), 32'd0);
        chk("midfetch_rst_state", 32'(sd3), 32'd0);
        tick();
        chk("held_rst_outs", 32'(o3), 32'd0);
        reset = 1'b1;
        tick();
        chk("init2_reg_write", 32'(o3.reg_write), 32'd1);
        run_instr(1'b0);
        chk("fetch_len", tr.size(), 32'd3);
        chk("fetch_mrd", n_mrd, 32'd3);
        chk("fetch_irpc", 32'({o3.ir_write, o3.pc_write, o3.mem_read}), 32'd6);

        // add, no overflow
        run_instr(1'b0);
        chk("add_len", tr.size(), 32'd7);
        chk("add_d0_aluout", 32'(tr[0].aluout_write), 32'd1);
        chk("add_d0_srcb", 32'(tr[0].alu_src_b), 32'd3);
        chk("add_d1_ab", 32'({tr[1].a_write, tr[1].b_write}), 32'd3);
        chk("add_ex_srca", 32'(tr[2].alu_src_a), 32'd1);
        chk("add_ex_op", 32'(tr[2].alu_op), 32'd1);
        chk("add_wb_reg", 32'(tr[3].reg_write), 32'd1);
        chk("add_wb_dst", 32'(tr[3].reg_dst_sel), 32'd1);
        chk("add_wb_dsrc", 32'(tr[3].data_src_sel), 32'd0);
        chk("add_nreg", n_reg, 32'd1);

        // sub with overflow traps
        funct = 6'b100010; overflow = 1'b1;
        run_instr(1'b0);
        chk("sub_len", tr.size(), 32'd12);
        chk("sub_ex_op", 32'(tr[2].alu_op), 32'd2);
        chk("sub_exc_sel", 32'(tr[3].excp_sel), 32'd1);
        chk("sub_exc_iord", 32'(tr[3].iord_sel), 32'd3);
        chk("sub_exc_op", 32'(tr[3].alu_op), 32'd2);
        chk("sub_nreg", n_reg, 32'd0);
        chk("sub_nepc", n_epc, 32'd1);
        chk("sub_epc_cycle", 32'(tr[6].epc_write), 32'd1);
        chk("sub_vec_pcw", 32'(tr[8].pc_write), 32'd1);
        chk("sub_vec_pcsrc", 32'(tr[8].pc_src), 32'd3);
        chk("sub_npcw", n_pcw, 32'd1);
        chk("sub_nmrd", n_mrd, 32'd6);
        chk("sub_nmdr", n_mdr, 32'd1);

        // and ignores overflow
        funct = 6'b100100; overflow = 1'b1;
        run_instr(1'b0);
        chk("and_len", tr.size(), 32'd7);
        chk("and_op", 32'(tr[2].alu_op), 32'd3);
        chk("and_nreg", n_reg, 32'd1);
        chk("and_nepc", n_epc, 32'd0);

        // unknown opcode
        opcode = 6'b111111; funct = 6'b100000; overflow = 1'b0;
        run_instr(1'b0);
        chk("badop_len", tr.size(), 32'd11);
        chk("badop_iord", 32'(tr[2].iord_sel), 32'd3);
        chk("badop_sel", 32'(tr[2].excp_sel), 32'd0);
        chk("badop_mrd", 32'(tr[2].mem_read), 32'd1);
        chk("badop_nepc", n_epc, 32'd1);
        chk("badop_nreg", n_reg, 32'd0);
        chk("badop_pcsrc", 32'(tr[7].pc_src), 32'd3);

        // unknown funct
        opcode = 6'b000000; funct = 6'b000111;
        run_instr(1'b0);
        chk("badfn_len", tr.size(), 32'd11);
        chk("badfn_sel", 32'(tr[2].excp_sel), 32'd2);
        chk("badfn_nepc", n_epc, 32'd1);

        // addi without and with overflow
        opcode = 6'b001000; overflow = 1'b0;
        run_instr(1'b0);
        chk("addi_len", tr.size(), 32'd7);
        chk("addi_srcb", 32'(tr[2].alu_src_b), 32'd2);
        chk("addi_wb_reg", 32'(tr[3].reg_write), 32'd1);
        chk("addi_wb_dst", 32'(tr[3].reg_dst_sel), 32'd0);
        overflow = 1'b1;
        run_instr(1'b0);
        chk("addiov_len", tr.size(), 32'd12);
        chk("addiov_sel", 32'(tr[3].excp_sel), 32'd1);
        chk("addiov_nreg", n_reg, 32'd0);

        // beq taken / not taken
        opcode = 6'b000100; overflow = 1'b0; zero = 1'b1;
        run_instr(1'b0);
        chk("beq1_len", tr.size(), 32'd7);
        chk("beq1_op", 32'(tr[2].alu_op), 32'd2);
        chk("beq1_pcw", 32'(tr[3].pc_write), 32'd1);
        chk("beq1_pcsrc", 32'(tr[3].pc_src), 32'd1);
        chk("beq1_npcw", n_pcw, 32'd1);
        zero = 1'b0;
        run_instr(1'b0);
        chk("beq0_len", tr.size(), 32'd6);
        chk("beq0_npcw", n_pcw, 32'd0);

        // jump
        opcode = 6'b000010;
        run_instr(1'b0);
        chk("j_len", tr.size(), 32'd6);
        chk("j_pcw", 32'(tr[2].pc_write), 32'd1);
        chk("j_pcsrc", 32'(tr[2].pc_src), 32'd2);

        // sw, overflow ignored
        opcode = 6'b101011; overflow = 1'b1;
        run_instr(1'b0);
        chk("sw_len", tr.size(), 32'd7);
        chk("sw_mw", 32'(tr[3].mem_write), 32'd1);
        chk("sw_iord", 32'(tr[3].iord_sel), 32'd1);
        chk("sw_nmwr", n_mwr, 32'd1);
        chk("sw_nreg", n_reg, 32'd0);
        overflow = 1'b0;

        // MEM_LAT=5, STACK_INIT=0 instance
        reset = 1'b0;
        tick();
        chk("si0_rst_outs", 32'(o5), 32'd0);
        reset = 1'b1;
        tick();
        chk("si0_first_state", 32'(sd5), 32'd2);
        chk("si0_first_mrd", 32'(o5.mem_read), 32'd1);
        chk("si0_first_reg", 32'(o5.reg_write), 32'd0);
        run_instr(1'b1);
        chk("si0_fetch_rest", tr.size(), 32'd4);
        chk("si0_fetch_pcw", 32'(o5.pc_write), 32'd1);

        opcode = 6'b100011;
        run_instr(1'b1);
        chk("lw_len", tr.size(), 32'd15);
        chk("lw_nlwrd", n_lwrd, 32'd5);
        chk("lw_nmrd", n_mrd, 32'd10);
        chk("lw_first_rd", 32'({tr[3].mem_read, tr[3].iord_sel}), 32'd5);
        chk("lw_mdr", 32'({tr[8].mdr_write, tr[8].mem_read}), 32'd2);
        chk("lw_wb_reg", 32'(tr[9].reg_write), 32'd1);
        chk("lw_wb_dsrc", 32'(tr[9].data_src_sel), 32'd1);
        chk("lw_wb_dst", 32'(tr[9].reg_dst_sel), 32'd0);
        chk("lw_nreg", n_reg, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
